// File: rtl/accdnn_pool_pkg.sv
// Shared constants and sizing helpers for the pooling stages of the LeNet pipeline.
package accdnn_pool_pkg;

  localparam int W_IN_DEF  = 24;
  localparam int H_IN_DEF  = 24;
  localparam int C_DEF     = 4;
  localparam int DW_DEF    = 16;

  localparam int W_OUT     = W_IN_DEF / 2;
  localparam int H_OUT     = H_IN_DEF / 2;
  localparam int LB_DEPTH  = W_OUT * C_DEF;
  localparam int OUT_BEATS = W_OUT * H_OUT * C_DEF;

  // Counter/pointer width that stays at least 1 bit for degenerate sizes.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int lb_depth(input int w_in, input int c);
    return (w_in / 2) * c;
  endfunction

endpackage

// File: rtl/pool_out_fifo.sv
// Synchronous FIFO holding pooled results plus their eop flag; head is shown combinationally.
module pool_out_fifo
  import accdnn_pool_pkg::*;
#(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNTW-1:0]  count
);

  localparam int PW = cnt_w(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;

  assign empty  = (count == '0);
  assign pop_ok = pop & ~empty;
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      count <= count + CNTW'(push) - CNTW'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pool1_layer.sv
// 2x2 stride-2 signed max pool over a channel-fastest activation stream, with
// a horizontal pair register, a half-width line buffer and a small output FIFO.
module pool1_layer
  import accdnn_pool_pkg::*;
#(
  parameter int W_IN       = W_IN_DEF,
  parameter int H_IN       = H_IN_DEF,
  parameter int C          = C_DEF,
  parameter int DW         = DW_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blob_din_en,
  input  logic          blob_din_eop,
  input  logic [DW-1:0] blob_din,
  output logic          blob_din_rdy,
  input  logic          blob_dout_rdy,
  output logic          blob_dout_en,
  output logic          blob_dout_eop,
  output logic [DW-1:0] blob_dout,
  output logic          frame_err
);

  localparam int LB_D = lb_depth(W_IN, C);
  localparam int CW   = cnt_w(C);
  localparam int WW   = cnt_w(W_IN);
  localparam int HW   = cnt_w(H_IN);
  localparam int AW   = cnt_w(LB_D);
  localparam int FCW  = cnt_w(FIFO_DEPTH + 1);

  localparam logic [CW-1:0]  C_LAST   = CW'(C - 1);
  localparam logic [WW-1:0]  W_LAST   = WW'(W_IN - 1);
  localparam logic [HW-1:0]  H_LAST   = HW'(H_IN - 1);
  localparam logic [FCW-1:0] RDY_THR  = FCW'(FIFO_DEPTH - 2);

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]  c_cnt;
  logic [WW-1:0]  w_cnt;
  logic [HW-1:0]  h_cnt;
  logic           accept;
  logic           at_last;
  logic [AW-1:0]  addr_p0;

  logic                 vld_p1;
  logic signed [DW-1:0] din_p1;
  logic [CW-1:0]        c_p1;
  logic                 w_odd_p1;
  logic                 h_odd_p1;
  logic [AW-1:0]        addr_p1;
  logic                 last_p1;

  logic signed [DW-1:0] hreg    [C];
  logic signed [DW-1:0] linebuf [LB_D];
  logic signed [DW-1:0] hmax_p1;
  logic signed [DW-1:0] vmax_p1;
  logic                 push_p1;

  logic [DW:0]    fifo_head;
  logic           fifo_empty;
  logic [FCW-1:0] fifo_count;
  logic [FCW-1:0] count_nxt;

  // Stage p0: accept, position counters and frame check
  assign accept  = blob_din_en & blob_din_rdy;
  assign at_last = (c_cnt == C_LAST) && (w_cnt == W_LAST) && (h_cnt == H_LAST);
  assign addr_p0 = AW'(int'(w_cnt >> 1) * C + int'(c_cnt));

  always_ff @(posedge clk) begin
    if (rst) begin
      c_cnt        <= '0;
      w_cnt        <= '0;
      h_cnt        <= '0;
      frame_err    <= 1'b0;
      vld_p1       <= 1'b0;
      blob_din_rdy <= 1'b0;
    end else begin
      blob_din_rdy <= (count_nxt <= RDY_THR);
      vld_p1       <= accept;
      if (accept) begin
        if (blob_din_eop && !at_last) begin
          frame_err <= 1'b1;
          c_cnt     <= '0;
          w_cnt     <= '0;
          h_cnt     <= '0;
        end else begin
          if (at_last && !blob_din_eop)
            frame_err <= 1'b1;
          if (c_cnt == C_LAST) begin
            c_cnt <= '0;
            if (w_cnt == W_LAST) begin
              w_cnt <= '0;
              h_cnt <= (h_cnt == H_LAST) ? '0 : h_cnt + 1'b1;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end else begin
            c_cnt <= c_cnt + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      din_p1   <= blob_din;
      c_p1     <= c_cnt;
      w_odd_p1 <= w_cnt[0];
      h_odd_p1 <= h_cnt[0];
      addr_p1  <= addr_p0;
      last_p1  <= at_last;
    end
  end

  // Stage p1: horizontal then vertical max, result pushed into the FIFO
  assign hmax_p1 = smax(hreg[c_p1], din_p1);
  assign vmax_p1 = smax(linebuf[addr_p1], hmax_p1);
  assign push_p1 = vld_p1 & w_odd_p1 & h_odd_p1;

  always_ff @(posedge clk) begin
    if (vld_p1 && !w_odd_p1)
      hreg[c_p1] <= din_p1;
    if (vld_p1 && w_odd_p1 && !h_odd_p1)
      linebuf[addr_p1] <= hmax_p1;
  end

  // Output stage: FIFO head presented whenever downstream is ready
  assign blob_dout_en  = ~fifo_empty & blob_dout_rdy;
  assign blob_dout     = fifo_empty ? '0 : fifo_head[DW-1:0];
  assign blob_dout_eop = ~fifo_empty & fifo_head[DW];
  assign count_nxt     = fifo_count + FCW'(push_p1) - FCW'(blob_dout_en);

  pool_out_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FIFO_DEPTH),
    .CNTW  (FCW)
  ) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_p1),
    .push_data ({last_p1, vmax_p1}),
    .pop       (blob_dout_en),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: doc/pool1_layer.md
# pool1_layer

Max-pooling stage directly downstream of the first convolution layer in the serial LeNet pipeline. Consumes the conv stage's 16-bit activation blob stream (24x24x4, channel-fastest order) and applies a 2x2, stride-2 max pool. Produces a 12x12x4 blob on the same valid/ready/eop stream protocol for the next layer. Sustains one input beat per cycle whenever downstream is ready.

## Interface
- `W_IN`, 24, input width; must be even.
- `H_IN`, 24, input height; must be even.
- `C`, 4, channels per pixel.
- `DW`, 16, data width; signed fixed-point, Q6.
- `FIFO_DEPTH`, 4, output FIFO entries; must be ≥ 3.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `blob_din_en` in 1: input beat valid; driven only while `blob_din_rdy` = 1.
- `blob_din_eop` in 1: marks the last beat of an input frame.
- `blob_din` in DW: input activation.
- `blob_din_rdy` out 1: block can accept a beat this cycle.
- `blob_dout_rdy` in 1: downstream can accept a beat.
- `blob_dout_en` out 1: output beat valid, consumed in the same cycle.
- `blob_dout_eop` out 1: last output beat of a frame.
- `blob_dout` out DW: pooled activation.
- `frame_err` out 1: sticky flag for an eop/count mismatch.

## Operation
- Input order: c fastest, then w, then h. Counters `c_cnt`, `w_cnt`, `h_cnt` advance on each accepted beat (`blob_din_en & blob_din_rdy`) and wrap to 0 after (H_IN-1, W_IN-1, C-1).
- Horizontal register `hreg[C]`:
  - even `w_cnt`: `hreg[c_cnt] <= din`.
  - odd `w_cnt`: `hmax = smax(hreg[c_cnt], din)`.
- Line buffer, depth (W_IN/2)*C, address `(w_cnt>>1)*C + c_cnt`:
  - odd w, even h: write `hmax`.
  - odd w, odd h: `vmax = smax(linebuf[addr], hmax)` is pushed to the output FIFO.
- `smax` is a signed two's-complement compare. No saturation, no width growth, output = DW bits.
- The output eop bit is pushed with the result produced by input beat (H_IN-1, W_IN-1, C-1).
- Output order: c fastest, then ow, then oh; (W_IN/2)*(H_IN/2)*C beats per frame.
- Frame check:
  - eop accepted on a non-final beat: set `frame_err`, reset counters to 0. Partial pooled data already pushed remains in the FIFO.
  - Final beat accepted without eop: set `frame_err`, counters wrap normally.
  - `frame_err` clears only on `rst`.
- Back-to-back frames need no gap.

## Timing
- Reset values: `blob_din_rdy`=0, `blob_dout_en`=0, `blob_dout_eop`=0, `blob_dout`=0, `frame_err`=0. Counters are 0 and the FIFO is empty. `blob_din_rdy` goes to 1 in the first cycle after `rst` deasserts.
- Pipeline: a beat accepted in cycle t is registered in t+1 and written to the FIFO at the end of t+1. The earliest `blob_dout_en` is t+2.
- `blob_din_rdy` is registered and equals `fifo_count <= FIFO_DEPTH-2`, which covers the in-flight pipeline register. The FIFO never overflows.
- `blob_dout_en` = FIFO not empty AND `blob_dout_rdy`. `blob_dout` and `blob_dout_eop` come from the FIFO head and are valid only with `blob_dout_en`.
- A FIFO push and pop in the same cycle is allowed; the count is unchanged.
- Reset mid-frame discards all partial state, including the FIFO contents. The next accepted beat is treated as (0,0,0).

## Structure
- Shared package (`accdnn_pool_pkg`): derived constants W_OUT = W_IN/2, H_OUT = H_IN/2, LB_DEPTH = W_OUT*C, OUT_BEATS = W_OUT*H_OUT*C, and the counter widths computed with clog2.
- One sub-module: `pool_out_fifo`, a synchronous FIFO with DW+1 bits (data plus eop), depth FIFO_DEPTH, and count output.
- The line buffer is distributed RAM with an asynchronous read inside `pool1_layer`.

## Test plan
- Ramp frame, `din = ((h*24+w)*4)+c`, `blob_dout_rdy`=1:
  - 576 outputs; first four are 100, 101, 102, 103; last is 2303 with `blob_dout_eop`=1.
  - `frame_err`=0; one input beat accepted per cycle.
- Signed max: a 2x2 window holding -5, -3, -7, -9 (channel 0) -> 0xFFFD. A window holding -1, 0, -32768, -2 -> 0x0000.
- Backpressure: `blob_dout_rdy`=0 for 20 cycles mid-frame:
  - `blob_din_rdy` falls once `fifo_count` ≥ 3, with no lost or duplicated beat.
  - Output sequence is identical to the ramp reference.
- Early eop on input beat 1000:
  - `frame_err`=1 and stays set.
  - The following clean ramp frame yields the correct 576 outputs.
- `rst` pulsed at input beat 500:
  - All outputs return to reset values the next cycle and the FIFO is empty.
  - The next full frame matches the reference exactly.
- Two back-to-back ramp frames with no idle cycle: 1152 outputs, exactly two eops, at output beats 575 and 1151.
